// File: rtl/bit_serializer_pkg.sv
// Shared types for the parallel-in/serial-out stage.
// State encoding matches the detector bench's view of the serializer.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Effective length: 0 or anything above the pattern width sends it all.
  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned width
  );
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load port and serial bit stream of the serializer.
// master drives loads and consumes bits; slave is the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    output load_len,
    output bit_ready,
    input  load_ready,
    input  bit_out,
    input  bit_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_len,
    input  bit_ready,
    output load_ready,
    output bit_out,
    output bit_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/bit_serializer_shift_reg.sv
// Loadable shifter with a serial tap at the outgoing end.
// Direction is fixed at elaboration by MSB_FIRST.
module bit_serializer_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             tap
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign tap = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage feeding the sequence detector.
// One bit per accepted transfer; done pulses once after the last bit.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic              clk,
  input logic              reset,
  bit_serializer_if.slave  bus
);

  import bit_serializer_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] eff_len;
  logic             tap;
  logic             load_fire;
  logic             xfer;
  logic             last;

  assign eff_len = LEN_W'(clamp_len(
    int'(unsigned'(bus.load_len)), WIDTH));

  assign load_fire = (state == S_IDLE) && bus.load_valid;
  assign xfer      = (state == S_SHIFT) && bus.bit_ready;
  assign last      = (count == len - LEN_W'(1));

  bit_serializer_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (load_fire),
    .shift (xfer),
    .data  (bus.load_data),
    .tap   (tap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.load_valid) state_nxt = S_SHIFT;
      S_SHIFT: if (bus.bit_ready && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // count stops at len, so it cannot wrap for any legal length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      len   <= '0;
    end else if (load_fire) begin
      count <= '0;
      len   <= eff_len;
    end else if (xfer) begin
      count <= count + LEN_W'(1);
    end
  end

  always_comb begin
    bus.load_ready = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_out    = IDLE_LEVEL;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): begin
        bus.load_ready = 1'b1;
      end
      (state == S_SHIFT): begin
        bus.bit_valid = 1'b1;
        bus.bit_out   = tap;
        bus.busy      = 1'b1;
      end
      (state == S_DONE): begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
